// File: rtl/rgb_fx_ctrl.sv
// RGB effect sequencer: turns game events into timed duty-load sequences
// for three PWM generators (green flash on eat, blue fade on start, red blink on over).
module rgb_fx_ctrl #(
    parameter int unsigned SIZE     = 4,
    parameter int unsigned TICK_DIV = 649606
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ev_start,
    input  logic            ev_eat,
    input  logic            ev_over,
    output logic            load_r,
    output logic            load_g,
    output logic            load_b,
    output logic [SIZE-1:0] duty_r,
    output logic [SIZE-1:0] duty_g,
    output logic [SIZE-1:0] duty_b,
    output logic            busy,
    output logic [1:0]      fx_id
);

    localparam int unsigned     CNT_W      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned     TCNT_W     = 3;
    localparam logic [SIZE-1:0] MAX        = '1;
    localparam logic [TCNT_W-1:0] LAST_FLASH = 3'd1;
    localparam logic [TCNT_W-1:0] LAST_BLINK = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLASH,
        S_BLINK,
        S_HOLD,
        S_FADE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [SIZE-1:0]     duty_r_q, duty_r_d, duty_g_q, duty_g_d, duty_b_q, duty_b_d;
    logic                load_r_q, load_r_d, load_g_q, load_g_d, load_b_q, load_b_d;
    logic                busy_q, busy_d;
    logic [1:0]          fx_id_q, fx_id_d;
    logic                tick;
    logic                go_blink;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    // Next-state, duty and strobe logic; ev_over preemption overrides the per-state result.
    always_comb begin
        state_d  = state_q;
        duty_r_d = duty_r_q;
        duty_g_d = duty_g_q;
        duty_b_d = duty_b_q;
        load_r_d = 1'b0;
        load_g_d = 1'b0;
        load_b_d = 1'b0;
        tcnt_d   = tick ? (tcnt_q + TCNT_W'(1)) : tcnt_q;
        cnt_d    = cnt_q;
        go_blink = ev_over && ((state_q == S_IDLE) || (state_q == S_FLASH) || (state_q == S_FADE));

        case (state_q)
            S_IDLE: begin
                if (ev_eat) begin
                    state_d  = S_FLASH;
                    duty_g_d = MAX;
                    load_g_d = 1'b1;
                end else if (ev_start) begin
                    state_d  = S_FADE;
                    duty_b_d = MAX;
                    load_b_d = 1'b1;
                end
            end
            S_FLASH: begin
                if (tick && (tcnt_q == LAST_FLASH)) begin
                    state_d  = S_IDLE;
                    duty_g_d = '0;
                    load_g_d = 1'b1;
                end
            end
            S_FADE: begin
                // Clamp at zero: the step that reaches 0 also ends the effect.
                if (tick) begin
                    if (duty_b_q > SIZE'(1)) begin
                        duty_b_d = duty_b_q - SIZE'(1);
                        load_b_d = 1'b1;
                    end else begin
                        duty_b_d = '0;
                        load_b_d = (duty_b_q != '0);
                        state_d  = S_IDLE;
                    end
                end
            end
            S_BLINK: begin
                if (tick) begin
                    load_r_d = 1'b1;
                    if (tcnt_q == LAST_BLINK) begin
                        duty_r_d = MAX;
                        state_d  = S_HOLD;
                    end else begin
                        duty_r_d = (duty_r_q == '0) ? MAX : '0;
                    end
                end
            end
            S_HOLD: begin
                if (ev_start) begin
                    state_d  = S_FADE;
                    duty_r_d = '0;
                    load_r_d = 1'b1;
                    duty_b_d = MAX;
                    load_b_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (go_blink) begin
            state_d  = S_BLINK;
            duty_r_d = MAX;
            duty_g_d = '0;
            duty_b_d = '0;
            load_r_d = 1'b1;
            load_g_d = 1'b1;
            load_b_d = 1'b1;
        end

        if (state_d != state_q) begin
            cnt_d  = '0;
            tcnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_FLASH:        fx_id_d = 2'd1;
            S_BLINK, S_HOLD: fx_id_d = 2'd2;
            S_FADE:         fx_id_d = 2'd3;
            default:        fx_id_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            duty_r_q <= '0;
            duty_g_q <= '0;
            duty_b_q <= '0;
            load_r_q <= 1'b0;
            load_g_q <= 1'b0;
            load_b_q <= 1'b0;
            busy_q   <= 1'b0;
            fx_id_q  <= 2'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            duty_r_q <= duty_r_d;
            duty_g_q <= duty_g_d;
            duty_b_q <= duty_b_d;
            load_r_q <= load_r_d;
            load_g_q <= load_g_d;
            load_b_q <= load_b_d;
            busy_q   <= busy_d;
            fx_id_q  <= fx_id_d;
        end
    end

    assign load_r = load_r_q;
    assign load_g = load_g_q;
    assign load_b = load_b_q;
    assign duty_r = duty_r_q;
    assign duty_g = duty_g_q;
    assign duty_b = duty_b_q;
    assign busy   = busy_q;
    assign fx_id  = fx_id_q;

endmodule
